// File: rtl/fb_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
// The writer state type and the address-width derivation live here.
package fb_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_WAIT_SWAP = 2'd2
  } wr_state_t;

  // A one-entry frame still needs a one-bit address bus.
  function automatic int calc_addr_w(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/frame_buf_pp_if.sv
// Write-stream and random-read bus of the ping-pong frame buffer.
// The master drives pixels and read requests, and the slave is the buffer itself.
interface frame_buf_pp_if #(
  parameter int DW     = 8,
  parameter int ADDR_W = 19
);

  logic              w_req;
  logic              w_valid;
  logic              w_ready;
  logic [DW-1:0]     din;
  logic              r_lock;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]     dout;
  logic              r_valid;
  logic              frame_done;
  logic              frame_avail;
  logic              w_busy;
  logic              restart_err;

  modport master (
    output w_req, w_valid, din, r_lock, r_en, r_addr,
    input  w_ready, dout, r_valid, frame_done, frame_avail, w_busy, restart_err
  );

  modport slave (
    input  w_req, w_valid, din, r_lock, r_en, r_addr,
    output w_ready, dout, r_valid, frame_done, frame_avail, w_busy, restart_err
  );

endinterface

// File: rtl/fb_bram.sv
// Two-bank simple dual-port pixel RAM with a registered read port.
// A read outside the frame returns zero but still reports valid data.
module fb_bram
  import fb_pkg::*;
#(
  parameter int FRAME  = 8,
  parameter int DW     = 8,
  parameter int ADDR_W = calc_addr_w(FRAME)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] FRAME_L = (ADDR_W + 1)'(FRAME);

  // Indexing by [bank][pixel] is the {bank, addr} layout without padding
  // each bank up to a power of two.
  logic [DW-1:0] mem [2][FRAME];
  logic          rd_in_range;

  assign rd_in_range = ({1'b0, rd_addr} < FRAME_L);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_bank][rd_addr] : '0;
      end
    end
  end

endmodule

// File: rtl/frame_buf_pp.sv
// Ping-pong frame buffer: the streaming writer fills one bank while the reader
// accesses the other, and a finished frame is published by a bank swap.
module frame_buf_pp
  import fb_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int BIT_WIDTH = 8,
  parameter int CHANNELS  = 1
) (
  input logic           clk,
  input logic           n_rst,
  frame_buf_pp_if.slave bus
);

  localparam int FRAME  = WIDTH * HEIGHT;
  localparam int ADDR_W = calc_addr_w(FRAME);
  localparam int DW     = CHANNELS * BIT_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic              wr_bank;
  logic              w_req_prev;
  logic [ADDR_W-1:0] w_addr;
  logic              w_flag;
  logic              at_last;
  logic              w_ready_i;
  logic              accept;
  logic              last_accept;
  logic              restart;
  logic              swap;
  logic              frame_done_q;
  logic              frame_avail_q;
  logic              restart_err_q;

  assign w_flag  = bus.w_req & ~w_req_prev;
  assign at_last = (w_addr == LAST_ADDR);

  // A new request edge stalls the stream for one cycle to restart the frame,
  // unless the final pixel is pending: finishing a frame beats restarting it.
  assign w_ready_i   = (state == S_WRITE) & (~w_flag | at_last);
  assign accept      = bus.w_valid & w_ready_i;
  assign last_accept = accept & at_last;
  assign restart     = (state == S_WRITE) & w_flag & ~last_accept;

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      S_IDLE: begin
        if (w_flag) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_accept) begin
          if (bus.r_lock) begin
            state_nxt = S_WAIT_SWAP;
          end else begin
            swap      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_SWAP: begin
        if (!bus.r_lock) begin
          swap      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      wr_bank       <= 1'b0;
      w_req_prev    <= 1'b0;
      w_addr        <= '0;
      frame_done_q  <= 1'b0;
      frame_avail_q <= 1'b0;
      restart_err_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      w_req_prev    <= bus.w_req;
      frame_done_q  <= swap;
      restart_err_q <= restart;
      if (swap) begin
        wr_bank       <= ~wr_bank;
        frame_avail_q <= 1'b1;
      end
      if (((state == S_IDLE) && w_flag) || restart) begin
        w_addr <= '0;
      end else if (accept && !at_last) begin
        w_addr <= w_addr + 1'b1;
      end
    end
  end

  // The reader always sees the bank the writer is not filling.
  fb_bram #(
    .FRAME  (FRAME),
    .DW     (DW),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (accept),
    .wr_bank  (wr_bank),
    .wr_addr  (w_addr),
    .wr_data  (bus.din),
    .rd_en    (bus.r_en),
    .rd_bank  (~wr_bank),
    .rd_addr  (bus.r_addr),
    .rd_data  (bus.dout),
    .rd_valid (bus.r_valid)
  );

  assign bus.w_ready     = w_ready_i;
  assign bus.w_busy      = (state != S_IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_avail = frame_avail_q;
  assign bus.restart_err = restart_err_q;

endmodule

// File: tb/tb_frame_buf_pp.sv
// Randomized bench for frame_buf_pp against a frame-level model: a queue of
// accepted pixels that becomes the published frame when a swap happens.
module tb_frame_buf_pp;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int CH    = 3;
  localparam int BW    = 8;
  localparam int FRAME = W * H;
  localparam int AW    = $clog2(FRAME);
  localparam int DW    = CH * BW;
  localparam int FRAME_S = 6;
  localparam int AW_S    = 3;
  localparam int DW_S    = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  frame_buf_pp_if #(.DW(DW), .ADDR_W(AW)) bus ();
  frame_buf_pp_if #(.DW(DW_S), .ADDR_W(AW_S)) bus_s ();

  frame_buf_pp #(.WIDTH(W), .HEIGHT(H), .BIT_WIDTH(BW), .CHANNELS(CH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  frame_buf_pp #(.WIDTH(3), .HEIGHT(2), .BIT_WIDTH(8), .CHANNELS(1)) dut_s (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_s)
  );

  // Reference model state
  bit            m_writing, m_waiting, m_req_prev, m_avail, m_pub_known;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pub[FRAME];

  logic          exp_ready, exp_busy, exp_done, exp_rerr, exp_avail, exp_rvalid;
  logic [DW-1:0] exp_dout;
  bit            exp_dout_known;
  logic          obs_ready, obs_busy, obs_done, obs_rerr, obs_avail, obs_rvalid;
  logic [DW-1:0] obs_dout;

  task automatic model_reset();
    m_writing = 0; m_waiting = 0; m_req_prev = 0; m_avail = 0; m_pub_known = 0;
    m_q.delete();
    exp_dout = '0; exp_dout_known = 1;
  endtask

  task automatic drive(input logic req, valid, lock, ren,
                       input logic [DW-1:0] d, input logic [AW-1:0] ra);
    bus.w_req = req; bus.w_valid = valid; bus.r_lock = lock;
    bus.r_en = ren; bus.din = d; bus.r_addr = ra;
  endtask

  // One clock cycle: entered and left at posedge+1, inputs already driven.
  task automatic step();
    bit flag, acc, swap;
    #3;
    flag      = bus.w_req && !m_req_prev;
    exp_ready = m_writing && (!flag || m_q.size() == FRAME - 1);
    exp_busy  = m_writing || m_waiting;
    obs_ready = bus.w_ready;
    obs_busy  = bus.w_busy;
    acc       = bus.w_valid && exp_ready;
    exp_done = 0; exp_rerr = 0; swap = 0;
    exp_rvalid = bus.r_en;
    if (bus.r_en) begin
      exp_dout       = m_pub[bus.r_addr];
      exp_dout_known = m_pub_known;
    end
    if (m_writing) begin
      if (acc) begin
        m_q.push_back(bus.din);
        if (m_q.size() == FRAME) begin
          m_writing = 0;
          if (bus.r_lock) m_waiting = 1;
          else swap = 1;
        end
      end else if (flag) begin
        m_q.delete();
        exp_rerr = 1;
      end
    end else if (m_waiting) begin
      if (!bus.r_lock) begin
        m_waiting = 0;
        swap = 1;
      end
    end else if (flag) begin
      m_writing = 1;
      m_q.delete();
    end
    m_req_prev = bus.w_req;
    if (swap) begin
      for (int i = 0; i < FRAME; i++) m_pub[i] = m_q[i];
      m_pub_known = 1;
      m_avail     = 1;
      exp_done    = 1;
    end
    exp_avail = m_avail;
    @(posedge clk);
    #1;
    obs_done   = bus.frame_done;
    obs_rerr   = bus.restart_err;
    obs_avail  = bus.frame_avail;
    obs_rvalid = bus.r_valid;
    obs_dout   = bus.dout;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, '0, '0);
    #2 n_rst = 1'b0;
    #2;
    total++;
    if ({bus.w_ready, bus.r_valid, bus.frame_done, bus.frame_avail, bus.w_busy, bus.restart_err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b exp=000000", {bus.w_ready, bus.r_valid, bus.frame_done,
               bus.frame_avail, bus.w_busy, bus.restart_err});
    end
    total++;
    if (bus.dout !== '0) begin
      bad++;
      $display("[TB] FAIL reset_dout got=%h exp=0", bus.dout);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_single_frame();
    drive(1, 0, 0, 0, '0, '0); step();
    drive(0, 0, 0, 0, '0, '0); step();
    total++;
    if (obs_ready !== exp_ready || obs_busy !== exp_busy) begin
      bad++;
      $display("[TB] FAIL start_ready got=%b%b exp=%b%b", obs_ready, obs_busy, exp_ready, exp_busy);
    end
    for (int i = 0; i < FRAME; i++) begin
      drive(0, 1, 0, 0, DW'($urandom), '0); step();
      total++;
      if (obs_ready !== exp_ready || obs_done !== exp_done) begin
        bad++;
        $display("[TB] FAIL single_px%0d ready/done got=%b%b exp=%b%b", i, obs_ready, obs_done, exp_ready, exp_done);
      end
    end
    drive(0, 0, 0, 0, '0, '0); step();
    total++;
    if (obs_done !== exp_done || obs_busy !== exp_busy || obs_avail !== exp_avail) begin
      bad++;
      $display("[TB] FAIL single_after done/busy/avail got=%b%b%b exp=%b%b%b",
               obs_done, obs_busy, obs_avail, exp_done, exp_busy, exp_avail);
    end
    for (int a = 0; a < FRAME; a++) begin
      drive(0, 0, 0, 1, '0, AW'(a)); step();
      total++;
      if (obs_rvalid !== exp_rvalid || !exp_dout_known || obs_dout !== exp_dout) begin
        bad++;
        $display("[TB] FAIL single_read a=%0d got=%b/%h exp=%b/%h", a, obs_rvalid, obs_dout, exp_rvalid, exp_dout);
      end
    end
    drive(0, 0, 0, 0, '0, '0); step();
    total++;
    if (obs_rvalid !== 1'b0 || obs_dout !== exp_dout) begin
      bad++;
      $display("[TB] FAIL read_hold got=%b/%h exp=0/%h", obs_rvalid, obs_dout, exp_dout);
    end
  endtask

  task automatic test_backpressure();
    int cycles = 0;
    drive(1, 0, 0, 0, '0, '0); step();
    while ((m_writing || m_waiting) && cycles < 200) begin
      drive(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), DW'($urandom), AW'($urandom));
      step();
      cycles++;
      total++;
      if (obs_ready !== exp_ready || obs_done !== exp_done || obs_rvalid !== exp_rvalid ||
          (exp_rvalid && obs_dout !== exp_dout)) begin
        bad++;
        $display("[TB] FAIL bp_cycle%0d rdy/done/rv/dout got=%b%b%b/%h exp=%b%b%b/%h", cycles, obs_ready,
                 obs_done, obs_rvalid, obs_dout, exp_ready, exp_done, exp_rvalid, exp_dout);
      end
    end
    total++;
    if (m_writing || m_waiting) begin
      bad++;
      $display("[TB] FAIL bp_timeout got=busy exp=idle within 200 cycles");
    end
    for (int a = 0; a < FRAME; a++) begin
      drive(0, 0, 0, 1, '0, AW'(a)); step();
      total++;
      if (obs_dout !== exp_dout) begin
        bad++;
        $display("[TB] FAIL bp_read a=%0d got=%h exp=%h", a, obs_dout, exp_dout);
      end
    end
  endtask

  task automatic test_deferred_swap();
    logic [AW-1:0] ra;
    drive(1, 0, 1, 0, '0, '0); step();
    for (int i = 0; i < FRAME; i++) begin
      drive(0, 1, 1, 0, DW'($urandom), '0); step();
    end
    for (int i = 0; i < 5; i++) begin
      ra = AW'($urandom);
      drive(1'(i == 2), 1, 1, 1, DW'($urandom), ra); step();
      total++;
      if (obs_ready !== exp_ready || obs_busy !== exp_busy || obs_done !== exp_done || obs_dout !== exp_dout) begin
        bad++;
        $display("[TB] FAIL defer_hold%0d rdy/busy/done/dout got=%b%b%b/%h exp=%b%b%b/%h", i, obs_ready,
                 obs_busy, obs_done, obs_dout, exp_ready, exp_busy, exp_done, exp_dout);
      end
    end
    drive(0, 0, 0, 1, '0, ra); step();
    total++;
    if (obs_done !== exp_done || obs_dout !== exp_dout) begin
      bad++;
      $display("[TB] FAIL defer_release done/dout got=%b/%h exp=%b/%h", obs_done, obs_dout, exp_done, exp_dout);
    end
    for (int a = 0; a < FRAME; a++) begin
      drive(0, 0, 0, 1, '0, AW'(a)); step();
      total++;
      if (obs_dout !== exp_dout || obs_done !== exp_done) begin
        bad++;
        $display("[TB] FAIL defer_read a=%0d got=%h exp=%h", a, obs_dout, exp_dout);
      end
    end
  endtask

  task automatic test_restart();
    drive(1, 0, 0, 0, '0, '0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, DW'($urandom), '0); step();
    end
    drive(1, 1, 0, 0, DW'($urandom), '0); step();
    total++;
    if (obs_ready !== exp_ready || obs_rerr !== exp_rerr || obs_done !== exp_done) begin
      bad++;
      $display("[TB] FAIL restart_edge rdy/rerr/done got=%b%b%b exp=%b%b%b",
               obs_ready, obs_rerr, obs_done, exp_ready, exp_rerr, exp_done);
    end
    for (int i = 0; i < FRAME; i++) begin
      drive(0, 1, 0, 0, DW'($urandom), '0); step();
      total++;
      if (obs_done !== exp_done || obs_rerr !== exp_rerr) begin
        bad++;
        $display("[TB] FAIL restart_px%0d done/rerr got=%b%b exp=%b%b", i, obs_done, obs_rerr, exp_done, exp_rerr);
      end
    end
    for (int a = 0; a < FRAME; a++) begin
      drive(0, 0, 0, 1, '0, AW'(a)); step();
      total++;
      if (obs_dout !== exp_dout) begin
        bad++;
        $display("[TB] FAIL restart_read a=%0d got=%h exp=%h", a, obs_dout, exp_dout);
      end
    end
  endtask

  task automatic test_boundary();
    logic [AW-1:0] ra;
    ra = AW'(FRAME - 1);
    drive(1, 0, 0, 0, '0, '0); step();
    for (int i = 0; i < FRAME - 1; i++) begin
      drive(0, 1, 0, 0, DW'($urandom), '0); step();
    end
    // final pixel, a new request edge and a read all land in the swap cycle
    drive(1, 1, 0, 1, DW'($urandom), ra); step();
    total++;
    if (obs_done !== exp_done || obs_rerr !== exp_rerr || obs_dout !== exp_dout) begin
      bad++;
      $display("[TB] FAIL swap_cycle_read done/rerr/dout got=%b%b/%h exp=%b%b/%h",
               obs_done, obs_rerr, obs_dout, exp_done, exp_rerr, exp_dout);
    end
    drive(1, 0, 0, 1, '0, ra); step();
    total++;
    if (obs_busy !== exp_busy || obs_dout !== exp_dout) begin
      bad++;
      $display("[TB] FAIL after_swap_read busy/dout got=%b/%h exp=%b/%h", obs_busy, obs_dout, exp_busy, exp_dout);
    end
    drive(0, 1, 0, 0, '0, '0); step();
    total++;
    if (obs_busy !== exp_busy || obs_ready !== exp_ready) begin
      bad++;
      $display("[TB] FAIL ignored_edge busy/ready got=%b%b exp=%b%b", obs_busy, obs_ready, exp_busy, exp_ready);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1, 0, 0, 0, '0, '0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, DW'($urandom), AW'(i)); step();
    end
    drive(0, 0, 0, 0, '0, '0);
    n_rst = 1'b0;
    #2;
    total++;
    if ({bus.w_ready, bus.r_valid, bus.frame_done, bus.frame_avail, bus.w_busy, bus.restart_err} !== 6'b0 ||
        bus.dout !== '0) begin
      bad++;
      $display("[TB] FAIL midframe_reset got=%b/%h exp=000000/0", {bus.w_ready, bus.r_valid, bus.frame_done,
               bus.frame_avail, bus.w_busy, bus.restart_err}, bus.dout);
    end
    model_reset();
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, DW'($urandom), '0); step();
      total++;
      if (obs_ready !== exp_ready || obs_busy !== exp_busy || obs_avail !== exp_avail) begin
        bad++;
        $display("[TB] FAIL post_reset%0d rdy/busy/avail got=%b%b%b exp=%b%b%b", i,
                 obs_ready, obs_busy, obs_avail, exp_ready, exp_busy, exp_avail);
      end
    end
  endtask

  task automatic test_oob_read();
    logic [DW_S-1:0] px[FRAME_S];
    bit seen = 0;
    bus_s.w_req = 1'b1;
    @(posedge clk); #1;
    bus_s.w_req = 1'b0;
    for (int i = 0; i < FRAME_S; i++) begin
      px[i] = DW_S'($urandom_range(1, 255));
      bus_s.w_valid = 1'b1;
      bus_s.din = px[i];
      @(posedge clk); #1;
    end
    bus_s.w_valid = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      if (bus_s.frame_done === 1'b1) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL oob_frame_done got=0 exp=1 within 4 cycles");
    end
    for (int a = FRAME_S - 1; a < 8; a++) begin
      bus_s.r_en = 1'b1;
      bus_s.r_addr = AW_S'(a);
      @(posedge clk); #1;
      total++;
      if (bus_s.r_valid !== 1'b1 || bus_s.dout !== ((a < FRAME_S) ? px[FRAME_S - 1] : 8'h00)) begin
        bad++;
        $display("[TB] FAIL oob_read a=%0d got=%b/%h exp=1/%h", a, bus_s.r_valid, bus_s.dout,
                 (a < FRAME_S) ? px[FRAME_S - 1] : 8'h00);
      end
    end
    bus_s.r_en = 1'b0;
  endtask

  initial begin
    bus_s.w_req = 0; bus_s.w_valid = 0; bus_s.din = '0;
    bus_s.r_lock = 0; bus_s.r_en = 0; bus_s.r_addr = '0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_deferred_swap();
    test_restart();
    test_boundary();
    test_reset_midframe();
    test_single_frame();
    test_oob_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/frame_buf_pp.md
# frame_buf_pp

Ping-pong (double-buffered) image frame memory with a streaming write port and a random-access read port, for the image-processing path between the camera/DMA ingest and the pixel-processing cores. It generalises the single-bank image memory: configurable channel count, per-pixel valid/ready write flow control, and two banks so a full frame can be read while the next one is written. Completed frames are published by an atomic bank swap, which the reader can defer.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- BIT_WIDTH, 8, bits per channel
- CHANNELS, 1, channels per pixel, packed with channel 0 in the LSBs
- Derived: FRAME = WIDTH*HEIGHT; ADDR_W = $clog2(FRAME); DW = CHANNELS*BIT_WIDTH
- clk  in  1  single clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- w_req  in  1  frame write request; its rising edge starts a frame
- w_valid  in  1  din holds a pixel
- w_ready  out  1  pixel accepted when w_valid & w_ready
- din  in  DW  write pixel
- r_lock  in  1  reader holds the current read bank and defers the swap
- r_en  in  1  read strobe
- r_addr  in  ADDR_W  read pixel index, 0..FRAME-1
- dout  out  DW  read data
- r_valid  out  1  dout valid
- frame_done  out  1  one-cycle pulse on bank swap
- frame_avail  out  1  at least one complete frame has been published
- w_busy  out  1  writer in WRITE or WAIT_SWAP
- restart_err  out  1  one-cycle pulse when a partial frame is aborted

## Operation
- Bank bit wr_bank, reset 0. The read bank is always ~wr_bank.
- Edge detect: w_flag = w_req & ~w_req_prev. w_req_prev resets to 0.
- Writer FSM, reset IDLE:
  - IDLE: w_flag moves to WRITE with w_addr=0.
  - WRITE: w_ready=1. On each accepted pixel, din is written to the write bank at w_addr and w_addr increments.
  - WRITE, last pixel accepted (w_addr==FRAME-1): if r_lock=0, swap and go to IDLE; otherwise go to WAIT_SWAP.
  - WRITE with w_flag and no last-pixel acceptance that cycle: w_addr returns to 0, same bank, no swap, restart_err pulses, FSM stays in WRITE. Pixels are not accepted in that cycle (w_ready=0 for that cycle).
  - WAIT_SWAP: w_ready=0 and w_flag is ignored. In the first cycle with r_lock=0, swap and go to IDLE.
- Swap means: wr_bank toggles, frame_done pulses, frame_avail is set. frame_avail is sticky until reset.
- Read: a read in cycle t returns the rd_bank value sampled in cycle t. If r_addr >= FRAME, dout is 0 and r_valid is still 1.
- The writer and reader never address the same bank. There is no read/write collision case.
- Asynchronous reset mid-frame: FSM goes to IDLE, all flags clear, wr_bank=0. RAM contents are not cleared.

## Timing
- Reset values: w_ready=0, dout=0, r_valid=0, frame_done=0, frame_avail=0, w_busy=0, restart_err=0.
- w_req rising edge sampled at cycle t: w_ready=1 and w_busy=1 from t+1.
- Last pixel accepted at t with r_lock=0: at t+1 frame_done=1 (for one cycle only), w_ready=0, w_busy=0, and the bank is swapped.
- Read latency is 1: r_en at t gives dout and r_valid at t+1. When r_en=0, r_valid=0 and dout holds its value.
- Swap and read in the same cycle t: the read returns old-bank data. Reads from t+1 onward use the new bank.
- A w_req rising edge in the same cycle as the final-pixel acceptance is ignored.

## Structure
- Package fb_pkg holds:
  - the state enum {S_IDLE, S_WRITE, S_WAIT_SWAP}
  - the ADDR_W derivation function.
- Sub-module fb_bram: simple dual-port RAM with depth 2*FRAME and width DW, 1-cycle registered read.
  - Write address is {wr_bank, w_addr}.
  - Read address is {~wr_bank, r_addr}.

## Test plan
- Reset check: hold n_rst=0 mid-stream, release -> all outputs 0, wr_bank=0, no write accepted without a new w_req edge.
- Single frame, WIDTH=4, HEIGHT=2, CHANNELS=3:
  - stimulus: w_req edge, then 8 pixels with w_valid=1
  - response: frame_done pulses exactly one cycle after pixel 7; reading r_addr 0..7 returns the written pixels with 1-cycle latency.
- Back-pressure and gaps: toggle w_valid randomly -> only pixels with w_valid&w_ready are stored, in order; w_addr does not advance on idle cycles.
- Deferred swap:
  - stimulus: hold r_lock=1 across the end of frame 2
  - response: FSM stays in WAIT_SWAP with w_ready=0 and reads still return frame 1; the cycle after r_lock falls, frame_done pulses and reads return frame 2.
- Restart: w_req edge after 3 of 8 pixels -> restart_err pulses, w_addr=0, no swap. Write 8 more pixels -> frame_done fires; the read bank holds only the new 8 pixels.
- Boundary reads:
  - r_addr=FRAME-1 returns the last pixel; r_addr=FRAME returns dout=0 with r_valid=1.
  - A read issued in the swap cycle returns old-bank data.
